// File: rtl/bitonic_sort_seq32_if.sv
// rtl/bitonic_sort_seq32_if.sv - handshake bundle between bitonic_sort_seq32 and its neighbours
// Purpose: groups the input word stream, the sorted output stream and the busy flag.
// Signals (slave view = the sorter):
//   in_valid  in   input word valid
//   in_ready  out  sorter accepts an input word
//   in_data   in   32-bit unsigned input word
//   in_dir    in   sort direction (1 = ascending), sampled with the first word of a block
//   out_valid out  sorted word valid
//   out_ready in   downstream accepts a sorted word
//   out_data  out  sorted word
//   out_last  out  marks the K-th word of a block
//   busy      out  sorter not idle
interface bitonic_sort_seq32_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_dir;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;

   modport slave (
      input  in_valid, in_data, in_dir, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );

   modport master (
      output in_valid, in_data, in_dir, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/bitonic_sort_seq32.sv
// rtl/bitonic_sort_seq32.sv - sequential bitonic sorter for blocks of K 32-bit words
// Purpose: loads K words, runs the bitonic network one pass per cycle over the
//   slot array, then streams the sorted slots out in order.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave modport)   input/output word streams and busy flag
//   sort_count[15:0]      completed blocks, wraps       (BITONIC_SORT_SEQ_STATS_EN only)
//   stall_count[15:0]     stalled output cycles, saturates (BITONIC_SORT_SEQ_STATS_EN only)
// Parameter K: words per block, power of two, 2..32.
module bitonic_sort_seq32 #(
   parameter int K = 8
) (
   input  logic clk,
   input  logic rst_n,
   bitonic_sort_seq32_if.slave bus
`ifdef BITONIC_SORT_SEQ_STATS_EN
   ,
   output logic [15:0] sort_count,
   output logic [15:0] stall_count
`endif
);
   localparam int L = $clog2(K);
   localparam int IW = L;
   localparam logic [2:0] L_LAST = 3'(L);
   localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SORT, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [31:0]   slot_q [K];
   logic [31:0]   slot_d [K];
   logic [31:0]   net    [K];
   logic [IW-1:0] idx_q, idx_d, idx_nx;
   logic [2:0]    p_q, p_d, q_q, q_d;
   logic          dir_q, dir_d;
   logic          init_q;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          in_ready_w, in_fire, out_fire;

   // init_q keeps in_ready low until the first edge after reset release.
   assign in_ready_w    = init_q && (state_q == IDLE || state_q == LOAD);
   assign in_fire       = bus.in_valid && in_ready_w;
   assign out_fire      = out_valid_q && bus.out_ready;
   assign idx_nx        = idx_q + 1'b1;
   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = (state_q != IDLE);

   // One bitonic pass: partner distance 2^(q-1); the final merge stage (p = L)
   // follows the latched direction, earlier stages alternate on bit p of i.
   always_comb begin
      logic [2:0] sh;
      int         j;
      logic       asc;
      net = slot_q;
      sh  = (q_q == 3'd0) ? 3'd0 : q_q - 3'd1;
      j   = 0;
      asc = 1'b0;
      for (int i = 0; i < K; i++) begin
         j   = i ^ (1 << sh);
         asc = (p_q == L_LAST) ? dir_q : (((i >> p_q) & 1) == 0);
         if (j > i && j < K) begin
            // strict compares keep equal values in place
            if (asc ? (slot_q[i] > slot_q[IW'(j)]) : (slot_q[i] < slot_q[IW'(j)])) begin
               net[i]      = slot_q[IW'(j)];
               net[IW'(j)] = slot_q[i];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      idx_d       = idx_q;
      p_d         = p_q;
      q_d         = q_q;
      dir_d       = dir_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               slot_d[0] = bus.in_data;
               dir_d     = bus.in_dir;
               idx_d     = IW'(1);
               state_d   = LOAD;
            end
         end
         LOAD: begin
            if (in_fire) begin
               slot_d[idx_q] = bus.in_data;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  p_d     = 3'd1;
                  q_d     = 3'd1;
                  state_d = SORT;
               end else begin
                  idx_d = idx_nx;
               end
            end
         end
         SORT: begin
            slot_d = net;
            if (q_q == 3'd1) begin
               if (p_q == L_LAST) begin
                  p_d     = '0;
                  q_d     = '0;
                  state_d = DRAIN;
               end else begin
                  p_d = p_q + 3'd1;
                  q_d = p_q + 3'd1;
               end
            end else begin
               q_d = q_q - 3'd1;
            end
         end
         DRAIN: begin
            // Output word is registered: the first DRAIN cycle loads slot 0,
            // later words load on each accepted beat.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = slot_q[idx_q];
               out_last_d  = (idx_q == IDX_LAST);
            end else if (out_fire) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  idx_d       = '0;
                  state_d     = IDLE;
               end else begin
                  idx_d      = idx_nx;
                  out_data_d = slot_q[idx_nx];
                  out_last_d = (idx_nx == IDX_LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int i = 0; i < K; i++) slot_q[i] <= '0;
         idx_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         dir_q       <= 1'b1;
         init_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         idx_q       <= idx_d;
         p_q         <= p_d;
         q_q         <= q_d;
         dir_q       <= dir_d;
         init_q      <= 1'b1;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

`ifdef BITONIC_SORT_SEQ_STATS_EN
   logic [15:0] sort_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sort_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == DRAIN && out_fire && out_last_q)
            sort_cnt_q <= sort_cnt_q + 16'd1;
         if (state_q == DRAIN && out_valid_q && !bus.out_ready && stall_cnt_q != 16'hFFFF)
            stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign sort_count  = sort_cnt_q;
   assign stall_count = stall_cnt_q;
`endif
endmodule
